// File: rtl/led_rand_pkg.sv
// Shared constants and LFSR step for the LED G-stage randomness source.
// Health monitoring is enabled with LED_RAND_HEALTH_EN.
package led_rand_pkg;

  localparam int LANE_W = 32;
  localparam logic [LANE_W-1:0] LFSR_TAPS = 32'h80200003;
  localparam logic [LANE_W-1:0] ZERO_SEED_SUB = 32'h1;

  localparam int RAND_PER_SBOX = 18;
  localparam int R1_OFF = 0;
  localparam int R2_OFF = 6;
  localparam int R3_OFF = 12;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_WARM = 2'd2;
  localparam logic [1:0] ST_RUN  = 2'd3;

  // One advance = 32 Galois steps, so every lane bit is replaced.
  function automatic logic [LANE_W-1:0] lfsr_adv(
    input logic [LANE_W-1:0] s
  );
    logic [LANE_W-1:0] v;
    v = s;
    for (int i = 0; i < LANE_W; i++) begin
      v = {1'b0, v[LANE_W-1:1]}
        ^ (v[0] ? LFSR_TAPS : '0);
    end
    return v;
  endfunction

endpackage

// File: rtl/led_rand_lane.sv
// One seeded 32-bit Galois LFSR lane with load and advance.
// Load has priority over advance; a zero seed is substituted.
module led_rand_lane
  import led_rand_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [LANE_W-1:0] word,
  input  logic              adv,
  output logic [LANE_W-1:0] q
);

  logic [LANE_W-1:0] nxt;

  assign nxt = lfsr_adv(q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= (word == '0) ? ZERO_SEED_SUB : word;
    end else if (adv) begin
      q <= nxt;
    end
  end

endmodule

// File: rtl/led_g_rand_source.sv
// Mask source for the 3-share LED G stage: seed, warm up, advance on demand.
// Optional LED_RAND_HEALTH_EN adds per-lane repetition checks and health_err.
module led_g_rand_source
  import led_rand_pkg::*;
#(
  parameter int NUM_SBOX = 16,
  parameter int NUM_LANE = 9,
  parameter int WARMUP   = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            seed_start,
  input  logic                            seed_valid,
  output logic                            seed_ready,
  input  logic [LANE_W-1:0]               seed_word,
  input  logic                            rand_req,
  output logic                            rand_valid,
  output logic [NUM_SBOX*RAND_PER_SBOX-1:0] rand_o,
  output logic                            busy
`ifdef LED_RAND_HEALTH_EN
  ,
  output logic                            health_err
`endif
);

  localparam int RW = NUM_SBOX * RAND_PER_SBOX;
  localparam int CW = $clog2(NUM_LANE);
  localparam int WW = $clog2(WARMUP + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(NUM_LANE - 1);
  localparam logic [WW-1:0] WARM_LAST = WW'(WARMUP - 1);

  logic [1:0]                 state;
  logic [CW-1:0]              cnt;
  logic [WW-1:0]              warm;
  logic [NUM_LANE*LANE_W-1:0] flat;
  logic                       adv;
  logic                       run;

  assign run = (state == ST_RUN);
  assign seed_ready = (state == ST_LOAD);
  assign busy = (state == ST_LOAD) || (state == ST_WARM);
  assign rand_o = flat[RW-1:0];

`ifdef LED_RAND_HEALTH_EN
  assign rand_valid = run && !health_err;
`else
  assign rand_valid = run;
`endif

  // A restart request always wins over advancing.
  assign adv = !seed_start
    && ((state == ST_WARM) || (rand_valid && rand_req));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      warm  <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (seed_start) begin
            state <= ST_LOAD;
            cnt   <= '0;
          end
        end
        ST_LOAD: begin
          if (seed_start) begin
            cnt <= '0;
          end else if (seed_valid) begin
            if (cnt == CNT_LAST) begin
              cnt   <= '0;
              warm  <= '0;
              state <= ST_WARM;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        ST_WARM: begin
          if (seed_start) begin
            state <= ST_LOAD;
            cnt   <= '0;
            warm  <= '0;
          end else if (warm == WARM_LAST) begin
            warm  <= '0;
            state <= ST_RUN;
          end else begin
            warm <= warm + 1'b1;
          end
        end
        ST_RUN: begin
          if (seed_start) begin
            state <= ST_LOAD;
            cnt   <= '0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < NUM_LANE; i++) begin : g_lane
    logic ld;
    assign ld = seed_ready && seed_valid && !seed_start
      && (cnt == CW'(i));
    led_rand_lane u_lane (
      .clk  (clk),
      .rst  (rst),
      .load (ld),
      .word (seed_word),
      .adv  (adv),
      .q    (flat[i*LANE_W +: LANE_W])
    );
  end

`ifdef LED_RAND_HEALTH_EN
  logic                run_adv_d;
  logic [NUM_LANE-1:0] hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_adv_d <= 1'b0;
    end else begin
      run_adv_d <= adv && run;
    end
  end

  // prev holds the pre-advance value; compare once the new one lands.
  for (genvar i = 0; i < NUM_LANE; i++) begin : g_health
    logic [2:0]        rep;
    logic [LANE_W-1:0] prev;
    logic [LANE_W-1:0] cur;
    assign cur = flat[i*LANE_W +: LANE_W];
    assign hit[i] = (rep >= 3'd3);
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rep  <= '0;
        prev <= '0;
      end else begin
        if (adv) prev <= cur;
        if (seed_start) begin
          rep <= '0;
        end else if (run_adv_d) begin
          if (cur != prev) rep <= '0;
          else if (rep != 3'd7) rep <= rep + 3'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      health_err <= 1'b0;
    end else if (seed_start) begin
      health_err <= 1'b0;
    end else if (|hit) begin
      health_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_led_g_rand_source.sv
// Randomized bench for led_g_rand_source against a lane-array model.
// Define LED_RAND_HEALTH_EN to also exercise the health monitor.
module tb_led_g_rand_source;

  localparam int NL = 9;
  localparam int RW = 288;
  localparam logic [31:0] TAPS = 32'h80200003;

  logic          clk = 1'b0;
  logic          rst;
  logic          seed_start;
  logic          seed_valid;
  logic          seed_ready;
  logic [31:0]   seed_word;
  logic          rand_req;
  logic          rand_valid;
  logic [RW-1:0] rand_o;
  logic          busy;
`ifdef LED_RAND_HEALTH_EN
  logic          health_err;
`endif

  int n_run = 0;
  int n_fail = 0;
  logic [31:0] m [NL];
  logic [31:0] sw [NL];

  always #5 clk = ~clk;

  led_g_rand_source u_dut (
    .clk        (clk),
    .rst        (rst),
    .seed_start (seed_start),
    .seed_valid (seed_valid),
    .seed_ready (seed_ready),
    .seed_word  (seed_word),
    .rand_req   (rand_req),
    .rand_valid (rand_valid),
    .rand_o     (rand_o),
    .busy       (busy)
`ifdef LED_RAND_HEALTH_EN
    ,
    .health_err (health_err)
`endif
  );

  task automatic check(input string tag,
                       input logic [RW-1:0] got,
                       input logic [RW-1:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference lane update: 32 Galois steps of x^32+x^22+x^2+x+1.
  function automatic logic [31:0] step32(input logic [31:0] v);
    logic [31:0] r;
    r = v;
    for (int k = 0; k < 32; k++) begin
      if (r[0]) r = (r >> 1) ^ TAPS;
      else r = r >> 1;
    end
    return r;
  endfunction

  function automatic logic [31:0] sub0(input logic [31:0] w);
    return (w == 32'h0) ? 32'h1 : w;
  endfunction

  task automatic model_adv();
    for (int i = 0; i < NL; i++) m[i] = step32(m[i]);
  endtask

  function automatic logic [RW-1:0] model_vec();
    logic [RW-1:0] r;
    r = '0;
    for (int i = 0; i < NL; i++) r[i*32 +: 32] = m[i];
    return r;
  endfunction

  // pre > 0: load pre junk words, then restart with a colliding word.
  task automatic do_seed(input int pre);
    int ready_cnt;
    int cyc;
    seed_start = 1'b1;
    @(negedge clk);
    seed_start = 1'b0;
    check("load_ready", seed_ready, 1);
    for (int j = 0; j < pre; j++) begin
      seed_valid = 1'b1;
      seed_word = $urandom;
      m[j] = sub0(seed_word);
      @(negedge clk);
    end
    if (pre > 0) begin
      seed_start = 1'b1;
      seed_valid = 1'b1;
      seed_word = $urandom;
      @(negedge clk);
      seed_start = 1'b0;
    end
    ready_cnt = 0;
    for (int i = 0; i < NL; i++) begin
      if (seed_ready) ready_cnt++;
      rand_req = 1'($urandom % 2);
      seed_valid = 1'b1;
      seed_word = sw[i];
      m[i] = sub0(sw[i]);
      @(negedge clk);
    end
    seed_valid = 1'b0;
    rand_req = 1'b0;
    check("ready_cycles", ready_cnt, NL);
    check("ready_drop", seed_ready, 0);
    cyc = 0;
    while (!rand_valid && cyc < 12) begin
      check("busy_warm", busy, 1);
      @(negedge clk);
      cyc++;
    end
    check("warm_latency", cyc, 4);
    check("busy_run", busy, 0);
    repeat (4) model_adv();
    check("warm_out", rand_o, model_vec());
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    seed_start = 1'b0;
    seed_valid = 1'b0;
    seed_word = '0;
    rand_req = 1'b0;
    for (int i = 0; i < NL; i++) m[i] = '0;
    repeat (3) @(negedge clk);
    check("rst_rand_o", rand_o, 0);
    check("rst_valid", rand_valid, 0);
    check("rst_ready", seed_ready, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;

    // Requests in IDLE must not advance the zero lanes.
    rand_req = 1'b1;
    repeat (3) @(negedge clk);
    rand_req = 1'b0;
    check("idle_hold", rand_o, 0);
    check("idle_busy", busy, 0);

    for (int i = 0; i < NL; i++) sw[i] = 32'(i + 1);
    do_seed(0);

    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("hold", rand_o, model_vec());
    end
    rand_req = 1'b1;
    @(negedge clk);
    rand_req = 1'b0;
    model_adv();
    check("single_adv", rand_o, model_vec());
    @(negedge clk);
    check("single_adv_hold", rand_o, model_vec());

    for (int k = 0; k < 40; k++) begin
      rand_req = 1'($urandom % 2);
      @(negedge clk);
      if (rand_req) model_adv();
      check("rand_run", rand_o, model_vec());
      check("run_valid", rand_valid, 1);
    end
    rand_req = 1'b0;

    // Zero seed on lane 3, plus a restart in the middle of LOAD.
    for (int i = 0; i < NL; i++) sw[i] = $urandom;
    sw[3] = 32'h0;
    do_seed(3);
    for (int k = 0; k < 20; k++) begin
      rand_req = 1'($urandom % 2);
      @(negedge clk);
      if (rand_req) model_adv();
      check("zs_run", rand_o, model_vec());
      check("zs_lane3_nz", rand_o[127:96] != 32'h0, 1);
    end

    // Reseed from RUN: request in the same cycle is dropped.
    seed_start = 1'b1;
    rand_req = 1'b1;
    @(negedge clk);
    seed_start = 1'b0;
    rand_req = 1'b0;
    check("reseed_valid", rand_valid, 0);
    check("reseed_ready", seed_ready, 1);
    check("reseed_noadv", rand_o, model_vec());
    for (int j = 0; j < 4; j++) begin
      seed_valid = 1'b1;
      seed_word = $urandom;
      m[j] = sub0(seed_word);
      @(negedge clk);
    end
    seed_valid = 1'b0;
    check("partial_load", rand_o, model_vec());
    check("partial_busy", busy, 1);
    rst = 1'b1;
    #1;
    check("abort_rand_o", rand_o, 0);
    check("abort_ready", seed_ready, 0);
    check("abort_busy", busy, 0);
    check("abort_valid", rand_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < NL; i++) m[i] = '0;
    @(negedge clk);
    check("post_rst_idle", seed_ready, 0);

`ifdef LED_RAND_HEALTH_EN
    begin
      int cyc;
      for (int i = 0; i < NL; i++) sw[i] = $urandom;
      do_seed(0);
      check("health_clean", health_err, 0);
      force u_dut.g_lane[0].u_lane.nxt = 32'hdeadbeef;
      cyc = 0;
      while (!health_err && cyc < 16) begin
        rand_req = rand_valid;
        @(negedge clk);
        cyc++;
      end
      rand_req = 1'b0;
      release u_dut.g_lane[0].u_lane.nxt;
      check("health_err", health_err, 1);
      check("health_valid", rand_valid, 0);
      seed_start = 1'b1;
      @(negedge clk);
      seed_start = 1'b0;
      check("health_clear", health_err, 0);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/led_g_rand_source.md
Name: led_g_rand_source

Overview:
- Fresh-randomness source for the 3-share, low-randomness LED G-function stage.
- Per S-box, the G stage takes three 6-bit masks, r1/r2/r3. This block produces all of them each cycle from a bank of seeded 32-bit LFSR lanes.
- It sits directly upstream of the per-S-box G component-function array.
- Provides seeding, warm-up and advance-on-demand, so the downstream pipeline gets fresh masks only on the cycles it consumes them.

Parameters:
- NUM_SBOX, 16, S-boxes fed per cycle.
- RAND_PER_SBOX, 18, bits per S-box (r1, r2, r3 at 6 bits each).
- NUM_LANE, 9, 32-bit LFSR lanes. NUM_LANE*32 must be ≥ NUM_SBOX*RAND_PER_SBOX (288).
- WARMUP, 4, full lane advances after seeding before output is valid.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- seed_start  in  1  one-cycle pulse; begins (re)seeding
- seed_valid  in  1  seed_word is valid
- seed_ready  out  1  block accepts a seed word this cycle
- seed_word  in  32  lane seed, lane 0 first
- rand_req  in  1  consumer takes the current rand_o this cycle
- rand_valid  out  1  rand_o holds fresh, warmed-up randomness
- rand_o  out  NUM_SBOX*18  S-box i bits [18i+5:18i]=r1, [18i+11:18i+6]=r2, [18i+17:18i+12]=r3
- busy  out  1  high in LOAD or WARM

Behaviour:
- Reset (async, rst=1): state=IDLE, all lanes=0, lane counter=0, warm counter=0. Outputs: seed_ready=0, rand_valid=0, busy=0, rand_o=0.
- rand_o = concatenation of lane states, lane 0 in the LSBs, truncated to 288 bits. It is registered, with no combinational path from rand_req.
- Lane update ("advance"):
  - 32 unrolled Galois steps per cycle, polynomial x^32+x^22+x^2+x+1, taps mask 32'h80200003.
  - Every bit of each lane is replaced per advance.
- States:
  - IDLE: seed_ready=0, rand_valid=0. seed_start → LOAD.
  - LOAD: seed_ready=1. Each cycle with seed_valid=1, the word is loaded into lane[cnt] and cnt increments.
    - A seed word of 0 is replaced by 32'h1 (no all-zero lane).
    - After lane NUM_LANE-1 loads: cnt clears → WARM.
  - WARM: all lanes advance every cycle, regardless of rand_req. After WARMUP cycles → RUN.
  - RUN: rand_valid=1. On rand_req=1, lanes advance and rand_o changes on the next edge. On rand_req=0, rand_o is held.
- Reseed: seed_start in RUN or WARM → LOAD next cycle.
  - rand_valid drops the same edge.
  - Lanes keep their contents until each one is overwritten.
- seed_start in LOAD restarts loading at lane 0; already-loaded lanes are retained until overwritten.
- seed_start and seed_valid in the same LOAD cycle: restart wins, the word is ignored.
- rand_req while rand_valid=0 is ignored (no advance outside WARM).
- rst mid-LOAD/WARM/RUN: immediate return to reset values. A new seed is required.
- busy = (state==LOAD) or (state==WARM).

Optional Feature:
- Macro: LED_RAND_HEALTH_EN.
- Defined:
  - Each lane has a 3-bit repetition counter and a 32-bit previous-value register.
  - On each RUN advance, a lane whose new value equals its previous value increments its counter; otherwise the counter clears.
  - Adds output port health_err (1 bit). It is set when any counter reaches 3 and is sticky until rst or seed_start.
  - While health_err=1, rand_valid is forced to 0.
- Undefined: no health_err port, no counters. Behaviour otherwise identical.

Decomposition:
- Shared package led_rand_pkg holds:
  - LANE_W=32
  - LFSR_TAPS=32'h80200003
  - ZERO_SEED_SUB=32'h1
  - state encoding IDLE/LOAD/WARM/RUN (2 bits)
  - RAND_PER_SBOX and the r1/r2/r3 bit offsets 0/6/12
- One sub-module: led_rand_lane. It holds one 32-bit lane register with a load port, advance enable, zero-seed substitution and the 32-step unrolled update. It is instantiated NUM_LANE times.

Test Plan:
- Reset check: assert rst for 3 cycles → rand_o=0, rand_valid=0, seed_ready=0, busy=0.
- Seed and warm-up:
  - Stimulus: seed_start, then words 1..9 with seed_valid held high.
  - Response: seed_ready high for 9 cycles, busy high through LOAD and WARM, rand_valid rises exactly 4 cycles after the last word.
  - rand_o must match a reference model's lanes after 4 advances.
- Hold/advance: in RUN, rand_req=0 for 5 cycles → rand_o constant. A single rand_req pulse → exactly one advance, equal to the model.
- Zero seed: seed lane 3 with 0 → lane 3 behaves as if seeded with 32'h1. rand_o bits [127:96] never all-zero.
- Reseed during RUN:
  - seed_start → rand_valid=0 on the next edge.
  - Abort by asserting rst after 4 words → all outputs back to reset values.
- Health (LED_RAND_HEALTH_EN defined): force lane 0 into a stuck next-value via a force on its update → health_err=1 after 3 repeated advances, rand_valid=0. seed_start clears health_err.
